// File: rtl/halt_mem_scanner_if.sv
// Memory test-bench port between the halt scanner and system_if.
// The scanner is the master: it owns tb_ctrl/ren/addr and receives the load word.
interface halt_mem_scanner_if;
  logic        tb_ctrl;
  logic        ren;
  logic [31:0] addr;
  logic [31:0] load;

  modport master (output tb_ctrl, output ren, output addr, input load);
  modport slave  (input tb_ctrl, input ren, input addr, output load);
endinterface

// File: rtl/halt_mem_scanner.sv
// Post-halt memory inspection sequencer. While the system is halted it takes over the
// memory port, reads one word at a time and holds the word/address pair steady for the
// board display. The word is stepped manually with debounced keys or the address
// switches, or automatically after a dwell period.
module halt_mem_scanner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned READ_LAT        = 2,
  parameter int unsigned DWELL_CYCLES    = 50000000
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               halt,
  input  logic               key_next_n,
  input  logic               key_prev_n,
  input  logic [15:0]        sw_addr,
  input  logic               auto_mode,
  halt_mem_scanner_if.master mem,
  output logic [31:0]        disp_word,
  output logic [15:0]        disp_addr,
  output logic               cap_valid
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RD_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(READ_LAT - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  localparam int NEXT = 0;
  localparam int PREV = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  // ---------------------------------------------------------------------------
  // Key conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]           key_raw;
  logic [1:0]           sync_meta;
  logic [1:0]           sync_key;
  logic [1:0]           db_level;
  logic [1:0]           key_evt;
  logic [1:0][DB_W-1:0] db_cnt;

  assign key_raw = {key_prev_n, key_next_n};

  // Two-flop synchroniser for the asynchronous pushbuttons (released = 1).
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: every clocked block uses non-blocking assignments so all flops sample
    // pre-edge values; blocking here would turn the two stages into one.
    if (!nRST) begin
      sync_meta <= 2'b11;
      sync_key  <= 2'b11;
    end else begin
      sync_meta <= key_raw;
      sync_key  <= sync_meta;
    end
  end

  // Debounce: accept a level only after DEBOUNCE_CYCLES consecutive differing samples,
  // and emit a one-cycle press event when the accepted level falls.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      db_level <= 2'b11;
      key_evt  <= '0;
      db_cnt   <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        key_evt[k] <= 1'b0;
        if (sync_key[k] == db_level[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db_level[k] <= sync_key[k];
          db_cnt[k]   <= '0;
          key_evt[k]  <= ~sync_key[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan sequencer
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [15:0]     cur_q, cur_d;
  logic [RD_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [13:0]     sw_last;
  logic            sw_pend_q, sw_pend_d;
  logic            sw_chg;
  logic            do_capture;
  logic            clr_valid;
  logic [15:0]     sw_aligned;
  logic            sw_unused;

  assign sw_aligned = {sw_addr[15:2], 2'b00};
  assign sw_chg     = (sw_addr[15:2] != sw_last);
  // The byte-offset switches have no effect on a word-aligned scan.
  assign sw_unused  = ^sw_addr[1:0];

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath controls. A switch move seen while a read is in flight
  // is remembered and applied once the sequencer is back in HOLD.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cur_d      = cur_q;
    rd_cnt_d   = '0;
    dwell_d    = dwell_q;
    sw_pend_d  = sw_pend_q;
    do_capture = 1'b0;
    clr_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        sw_pend_d = 1'b0;
        if (halt) begin
          state_d   = ISSUE;
          cur_d     = sw_aligned;
          clr_valid = 1'b1;
        end
      end
      ISSUE: begin
        if (sw_chg) sw_pend_d = 1'b1;
        if (rd_cnt_q == RD_LAST) state_d  = CAPTURE;
        else                     rd_cnt_d = rd_cnt_q + 1'b1;
      end
      CAPTURE: begin
        if (sw_chg) sw_pend_d = 1'b1;
        do_capture = 1'b1;
        dwell_d    = '0;
        state_d    = HOLD;
      end
      HOLD: begin
        sw_pend_d = 1'b0;
        if (auto_mode) begin
          if (dwell_q == DW_LAST) begin
            dwell_d = '0;
            cur_d   = cur_q + 16'd4;
            state_d = ISSUE;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end else if (key_evt[NEXT]) begin
          cur_d   = cur_q + 16'd4;
          state_d = ISSUE;
        end else if (key_evt[PREV]) begin
          cur_d   = cur_q - 16'd4;
          state_d = ISSUE;
        end else if (sw_chg || sw_pend_q) begin
          cur_d   = sw_aligned;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Releasing halt abandons whatever is in progress; the display keeps its last word.
    if (!halt) begin
      state_d    = IDLE;
      cur_d      = cur_q;
      rd_cnt_d   = '0;
      do_capture = 1'b0;
      clr_valid  = 1'b0;
    end
  end

  // Scan address, counters, switch history and the captured display pair.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cur_q     <= '0;
      rd_cnt_q  <= '0;
      dwell_q   <= '0;
      sw_last   <= '0;
      sw_pend_q <= 1'b0;
      disp_word <= '0;
      disp_addr <= '0;
      cap_valid <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      rd_cnt_q  <= rd_cnt_d;
      dwell_q   <= dwell_d;
      sw_last   <= sw_addr[15:2];
      sw_pend_q <= sw_pend_d;
      if (do_capture) begin
        disp_word <= mem.load;
        disp_addr <= cur_q;
      end
      if (clr_valid)       cap_valid <= 1'b0;
      else if (do_capture) cap_valid <= 1'b1;
    end
  end

  assign mem.tb_ctrl = (state_q != IDLE);
  assign mem.ren     = (state_q != IDLE);
  assign mem.addr    = {16'h0000, cur_q};

endmodule

// File: tb/tb_halt_mem_scanner.sv
// Scoreboard bench for halt_mem_scanner: stimulus tasks push the expected captures,
// a negedge monitor pops and compares each time the displayed pair changes.
`timescale 1ns/1ps
module tb_halt_mem_scanner;

  localparam int          DEB   = 4;
  localparam int          RL    = 2;
  localparam int          DW    = 8;
  localparam logic [31:0] XOR_K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        key_next_n = 1'b1;
  logic        key_prev_n = 1'b1;
  logic [15:0] sw_addr = 16'h0000;
  logic        auto_mode = 1'b0;
  logic [31:0] disp_word;
  logic [15:0] disp_addr;
  logic        cap_valid;

  halt_mem_scanner_if mem_if ();

  halt_mem_scanner #(
    .DEBOUNCE_CYCLES (DEB),
    .READ_LAT        (RL),
    .DWELL_CYCLES    (DW)
  ) dut (
    .CLK        (clk),
    .nRST       (rst_n),
    .halt       (halt),
    .key_next_n (key_next_n),
    .key_prev_n (key_prev_n),
    .sw_addr    (sw_addr),
    .auto_mode  (auto_mode),
    .mem        (mem_if),
    .disp_word  (disp_word),
    .disp_addr  (disp_addr),
    .cap_valid  (cap_valid)
  );

  initial forever #5 clk = ~clk;

  // Memory model: data for an address is valid READ_LAT (=2) cycles after it appears.
  logic [31:0] pipe1 = '0;
  logic [31:0] pipe2 = '0;
  always @(posedge clk) begin
    pipe1 <= mem_if.addr;
    pipe2 <= pipe1;
  end
  assign mem_if.load = pipe2 ^ XOR_K;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    int          gap;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b1;
  logic [15:0] cur = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [15:0] a, input int gap);
    exp_t e;
    e.a   = a;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: a capture is visible as a new display address or cap_valid rising.
  initial begin : monitor
    logic [15:0] prev_addr;
    logic        prev_valid;
    int          last_cap;
    exp_t        e;
    prev_addr  = '0;
    prev_valid = 1'b0;
    last_cap   = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && ((disp_addr != prev_addr) || (cap_valid && !prev_valid))) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_capture: got addr 0x%04h word 0x%08h, expected no capture",
                   disp_addr, disp_word);
        end else begin
          e = exp_q.pop_front();
          check("cap_addr", {16'h0, disp_addr}, {16'h0, e.a});
          check("cap_word", disp_word, {16'h0, e.a} ^ XOR_K);
          check("cap_valid", {31'h0, cap_valid}, 32'd1);
          if (e.gap > 0) check("cap_spacing", cyc - last_cap, e.gap);
        end
        last_cap = cyc;
      end
      prev_addr  = disp_addr;
      prev_valid = cap_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d captures still pending after %0d cycles, expected 0",
               name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic wait_drain(input string name);
    wait_empty(name);
    tick(8);
  endtask

  task automatic press(input bit nx, input bit pv, input int low);
    @(negedge clk);
    key_next_n = ~nx;
    key_prev_n = ~pv;
    repeat (low) @(negedge clk);
    key_next_n = 1'b1;
    key_prev_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic step_next(input int low);
    cur = cur + 16'd4;
    exp_push(cur, 0);
    press(1'b1, 1'b0, low);
    wait_drain("step_next");
  endtask

  task automatic step_prev(input int low);
    cur = cur - 16'd4;
    exp_push(cur, 0);
    press(1'b0, 1'b1, low);
    wait_drain("step_prev");
  endtask

  // A change of the word-address switches rescans there; a visible capture only
  // happens if the new word address differs from the one on display.
  task automatic set_sw(input logic [15:0] v);
    logic [15:0] nc;
    nc = {v[15:2], 2'b00};
    if (v[15:2] != sw_addr[15:2]) begin
      if (nc != cur) exp_push(nc, 0);
      cur = nc;
    end
    @(negedge clk);
    sw_addr = v;
    wait_drain("switch_move");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tb_ctrl"}, {31'h0, mem_if.tb_ctrl}, 32'd0);
    check({tag, "_ren"}, {31'h0, mem_if.ren}, 32'd0);
    check({tag, "_addr"}, mem_if.addr, 32'd0);
    check({tag, "_disp_word"}, disp_word, 32'd0);
    check({tag, "_disp_addr"}, {16'h0, disp_addr}, 32'd0);
    check({tag, "_cap_valid"}, {31'h0, cap_valid}, 32'd0);
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached, expected summary before it");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] r;
    int          op;

    // Reset state.
    tick(3);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // First scan after halt: sw 0x0013 reads word 0x0010.
    @(negedge clk);
    sw_addr = 16'h0013;
    halt    = 1'b1;
    cur     = 16'h0010;
    exp_push(cur, 0);
    @(posedge clk);
    #1;
    check("first_addr", mem_if.addr, 32'h0000_0010);
    check("first_ren", {31'h0, mem_if.ren}, 32'd1);
    check("first_tb_ctrl", {31'h0, mem_if.tb_ctrl}, 32'd1);
    tick(2);
    #1;
    check("first_not_yet_valid", {31'h0, cap_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("first_word_at_3", disp_word, 32'hA5A5_0010);
    check("first_valid_at_3", {31'h0, cap_valid}, 32'd1);
    wait_drain("first_scan");

    // Manual stepping: a 6-cycle press steps once, 2-cycle glitches do nothing.
    step_next(6);
    press(1'b1, 1'b0, 2);
    press(1'b0, 1'b1, 2);
    wait_drain("glitch");
    check("after_glitch_addr", {16'h0, disp_addr}, 32'h0000_0014);

    // Address wrap in both directions.
    set_sw(16'hFFFC);
    step_next(8);
    check("wrap_up", {16'h0, disp_addr}, 32'h0000_0000);
    step_prev(8);
    check("wrap_down", {16'h0, disp_addr}, 32'h0000_FFFC);

    // Randomised manual operations.
    for (int i = 0; i < 14; i++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: step_next(8);
        1: step_prev(8);
        2: begin
          cur = cur + 16'd4;
          exp_push(cur, 0);
          press(1'b1, 1'b1, 8);
          wait_drain("both_keys");
        end
        3: begin press(1'b1, 1'b0, 2); wait_drain("rand_glitch_next"); end
        4: begin press(1'b0, 1'b1, 2); wait_drain("rand_glitch_prev"); end
        5: begin r = 16'($urandom_range(0, 65535)); set_sw(r); end
        default: begin
          r = sw_addr;
          r[1:0] = 2'($urandom_range(0, 3));
          set_sw(r);
        end
      endcase
    end

    // Auto scan from 0x0100; keys are ignored while it runs.
    set_sw(16'h0200);
    set_sw(16'h0100);
    @(negedge clk);
    auto_mode = 1'b1;
    exp_push(16'h0104, 0);
    exp_push(16'h0108, DW + RL + 1);
    exp_push(16'h010C, DW + RL + 1);
    cur = 16'h010C;
    press(1'b1, 1'b0, 8);
    wait_empty("auto_scan");
    @(negedge clk);
    halt      = 1'b0;
    auto_mode = 1'b0;
    @(posedge clk);
    #1;
    check("halt_drop_ren", {31'h0, mem_if.ren}, 32'd0);
    check("halt_drop_tb_ctrl", {31'h0, mem_if.tb_ctrl}, 32'd0);
    check("halt_drop_keep_addr", {16'h0, disp_addr}, 32'h0000_010C);
    check("halt_drop_keep_valid", {31'h0, cap_valid}, 32'd1);
    tick(15);

    // Halt re-rise rescans at the switch address.
    @(negedge clk);
    sw_addr = 16'h1237;
    @(negedge clk);
    halt = 1'b1;
    cur  = 16'h1234;
    exp_push(cur, 0);
    @(posedge clk);
    #1;
    check("rescan_valid_clear", {31'h0, cap_valid}, 32'd0);
    check("rescan_addr", mem_if.addr, 32'h0000_1234);
    wait_drain("rescan");

    // Halt drop in the middle of a read.
    @(negedge clk);
    sw_addr = 16'h2000;
    @(posedge clk);
    #1;
    check("mid_issue_ren", {31'h0, mem_if.ren}, 32'd1);
    @(negedge clk);
    halt = 1'b0;
    @(posedge clk);
    #1;
    check("mid_drop_ren", {31'h0, mem_if.ren}, 32'd0);
    check("mid_drop_keep_word", disp_word, 32'h0000_1234 ^ XOR_K);
    check("mid_drop_keep_valid", {31'h0, cap_valid}, 32'd1);
    tick(8);
    @(negedge clk);
    halt = 1'b1;
    cur  = 16'h2000;
    exp_push(cur, 0);
    @(posedge clk);
    #1;
    check("rerise_valid_clear", {31'h0, cap_valid}, 32'd0);
    wait_drain("rerise");

    // Asynchronous reset while holding a captured word.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_valid", {31'h0, cap_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick(2);
    #1;
    check_all_zero("held_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
